// File: rtl/fifo_read_block.sv
// fifo_read_block: read-side FIFO controller with show-ahead output register; FIFO_READ_LEVEL_EN adds level_o
module fifo_read_block #(
  parameter int data_size = 8,
  parameter int addr_size = 4
) (
  input  logic                 read_clock_i,
  input  logic                 read_reset_i,
  input  logic [addr_size:0]   write_ptr_gray_i,
  input  logic [data_size-1:0] mem_data_i,
  input  logic                 ready_i,
  output logic [addr_size-1:0] read_addr_o,
  output logic [addr_size:0]   read_ptr_gray_o,
  output logic                 read_empty_o,
  output logic [data_size-1:0] data_o,
  output logic                 valid_o,
  output logic [addr_size:0]   level_o
);
  logic [addr_size:0] sync1_q, sync2_q, rbin_q, rbin_d, rgray_q, rgray_d, level_q, level_d;
  logic empty_q, empty_d, valid_q, valid_d, pop;
  logic [data_size-1:0] data_q, data_d;
`ifdef FIFO_READ_LEVEL_EN
  logic [addr_size:0] wbin;
`endif
  always_comb begin
    pop = ~empty_q & (~valid_q | ready_i);
    rbin_d = rbin_q + {{addr_size{1'b0}}, pop};
    rgray_d = rbin_d ^ (rbin_d >> 1);
    empty_d = rgray_d == sync2_q;
    valid_d = pop | (valid_q & ~ready_i);
    data_d = pop ? mem_data_i : data_q;
`ifdef FIFO_READ_LEVEL_EN
    wbin[addr_size] = sync2_q[addr_size];
    for (int i = addr_size - 1; i >= 0; i--) wbin[i] = wbin[i+1] ^ sync2_q[i];
    level_d = wbin - rbin_d;
`else
    level_d = '0;
`endif
  end
  always_ff @(posedge read_clock_i) begin
    if (read_reset_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      rbin_q <= '0;
      rgray_q <= '0;
      empty_q <= 1'b1;
      valid_q <= 1'b0;
      data_q <= '0;
      level_q <= '0;
    end else begin
      sync1_q <= write_ptr_gray_i;
      sync2_q <= sync1_q;
      rbin_q <= rbin_d;
      rgray_q <= rgray_d;
      empty_q <= empty_d;
      valid_q <= valid_d;
      data_q <= data_d;
      level_q <= level_d;
    end
  end
  assign read_addr_o = rbin_q[addr_size-1:0];
  assign read_ptr_gray_o = rgray_q;
  assign read_empty_o = empty_q;
  assign data_o = data_q;
  assign valid_o = valid_q;
  assign level_o = level_q;
endmodule

// File: tb/tb_fifo_read_block.sv
// tb_fifo_read_block: directed self-checking bench for fifo_read_block
module tb_fifo_read_block;
  logic clk = 0, rst = 0, ready = 0, empty, valid;
  logic [4:0] wptr = '0, wgray, rgray, level;
  logic [3:0] raddr;
  logic [7:0] data, mdata, exp;
  logic [7:0] mem [16];
  int total = 0, bad = 0;
  assign wgray = wptr ^ (wptr >> 1);
  assign mdata = mem[raddr];
  always #5 clk = ~clk;
  fifo_read_block #(.data_size(8), .addr_size(4)) dut (
    .read_clock_i(clk), .read_reset_i(rst), .write_ptr_gray_i(wgray), .mem_data_i(mdata),
    .ready_i(ready), .read_addr_o(raddr), .read_ptr_gray_o(rgray), .read_empty_o(empty),
    .data_o(data), .valid_o(valid), .level_o(level));

  task automatic do_reset();
    @(negedge clk);
    rst = 1; wptr = '0; ready = 0;
    repeat (3) @(negedge clk);
    rst = 0;
  endtask

  task automatic drain(input int n, input logic [3:0] pat);
    int got = 0, c = 0;
    logic held = 0;
    logic [7:0] hd = '0;
    while (got < n && c < 200) begin
      @(negedge clk);
      if (held) begin
        total++;
        if (valid !== 1'b1 || data !== hd) begin bad++; $display("FAIL hold_stable data=%h valid=%b required %h/1", data, valid, hd); end
      end
      ready = pat[c % 4]; c++;
      held = valid && !ready; hd = data;
      if (valid && ready) begin
        total++;
        if (data !== exp) begin bad++; $display("FAIL stream_word data=%h required %h", data, exp); end
        exp++; got++;
      end
    end
    @(posedge clk); #1 ready = 0;
    total++;
    if (got != n) begin bad++; $display("FAIL stream_count got=%0d required %0d", got, n); end
  endtask

  task automatic test_reset();
    rst = 1; wptr = '0; ready = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    total++;
    if ({empty, valid, data, raddr, rgray, level} !== {1'b1, 1'b0, 8'h00, 4'h0, 5'h00, 5'h00}) begin
      bad++; $display("FAIL reset empty=%b valid=%b data=%h addr=%h gray=%h level=%h required 1/0/00/0/00/00", empty, valid, data, raddr, rgray, level);
    end
  endtask

  task automatic test_single();
    do_reset();
    mem[0] = 8'hA5; wptr = 5'd1;
    repeat (2) @(negedge clk);
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL single_empty_e1 empty=%b required 1", empty); end
    @(negedge clk);
    total++;
    if (empty !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL single_e2 empty=%b valid=%b required 0/0", empty, valid); end
    @(negedge clk);
    total++;
    if ({valid, data, empty, raddr} !== {1'b1, 8'hA5, 1'b1, 4'h1}) begin
      bad++; $display("FAIL single_e3 valid=%b data=%h empty=%b addr=%h required 1/a5/1/1", valid, data, empty, raddr);
    end
    repeat (2) @(negedge clk);
    total++;
    if (valid !== 1'b1 || data !== 8'hA5) begin bad++; $display("FAIL single_hold valid=%b data=%h required 1/a5", valid, data); end
    ready = 1;
    @(negedge clk);
    ready = 0;
    total++;
    if (valid !== 1'b0 || data !== 8'hA5) begin bad++; $display("FAIL single_accept valid=%b data=%h required 0/a5", valid, data); end
  endtask

  task automatic test_burst();
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    wptr = 5'd16; ready = 1;
    repeat (3) @(negedge clk);
    total++;
    if (empty !== 1'b0) begin bad++; $display("FAIL burst_empty_e2 empty=%b required 0", empty); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      total++;
      if (valid !== 1'b1 || data !== 8'(k)) begin bad++; $display("FAIL burst_word%0d valid=%b data=%h required 1/%h", k, valid, data, 8'(k)); end
    end
    total++;
    if (empty !== 1'b1 || rgray !== 5'h18) begin bad++; $display("FAIL burst_end empty=%b gray=%h required 1/18", empty, rgray); end
    @(negedge clk);
    ready = 0;
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL burst_drained valid=%b required 0", valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 8; i++) mem[i] = 8'h30 + 8'(i);
    exp = 8'h30; wptr = 5'd8;
    drain(8, 4'b1001);
  endtask

  task automatic test_wrap();
    do_reset();
    exp = 8'h40;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 8; i++) mem[wptr[3:0] + 4'(i)] = 8'h40 + 8'(c * 8 + i);
      wptr = wptr + 5'd8;
      drain(8, 4'b1111);
    end
    total++;
    if (rgray !== 5'h0C || raddr !== 4'h8 || empty !== 1'b1) begin
      bad++; $display("FAIL wrap_end gray=%h addr=%h empty=%b required 0c/8/1", rgray, raddr, empty);
    end
  endtask

  task automatic test_level_reset();
    do_reset();
    for (int i = 0; i < 10; i++) mem[i] = 8'h70 + 8'(i);
    wptr = 5'd10;
    repeat (8) @(negedge clk);
    total++;
`ifdef FIFO_READ_LEVEL_EN
    if (level !== 5'd9 || valid !== 1'b1 || data !== 8'h70) begin bad++; $display("FAIL level_settle level=%0d valid=%b data=%h required 9/1/70", level, valid, data); end
`else
    if (level !== 5'd0 || valid !== 1'b1 || data !== 8'h70) begin bad++; $display("FAIL level_settle level=%0d valid=%b data=%h required 0/1/70", level, valid, data); end
`endif
    rst = 1; wptr = '0;
    @(negedge clk);
    rst = 0;
    total++;
    if ({level, valid, data, empty, rgray} !== {5'd0, 1'b0, 8'h00, 1'b1, 5'h00}) begin
      bad++; $display("FAIL level_reset level=%0d valid=%b data=%h empty=%b gray=%h required 0/0/00/1/00", level, valid, data, empty, rgray);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    exp = '0;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_wrap();
    test_level_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
